// File: rtl/sram_req_arbiter.sv
// sram_req_arbiter: shares one single-port synchronous SRAM between the
// instruction-fetch port and the load/store port of the core. Data accesses
// win by default; a streak counter forces a fetch grant after STREAK_MAX
// consecutive data grants while a fetch is waiting. Responses come back with
// a fixed latency of one cycle, steered by a small registered owner FSM.
module sram_req_arbiter #(
    parameter int unsigned STREAK_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    // instruction fetch port
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    // load/store port
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // SRAM side
    output logic        mem_en,
    output logic [3:0]  mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RESP_I = 2'd1,
        RESP_D = 2'd2
    } state_t;

    localparam logic [2:0] STREAK_LIM = 3'(STREAK_MAX);
    localparam bit         GUARD_ON   = (STREAK_MAX != 0);

    state_t     state_reg;
    logic [2:0] streak_reg;

    logic starve;
    logic gnt_d;
    logic gnt_i;

    // Grant decision: data first, unless a waiting fetch has been passed over
    // STREAK_MAX times in a row. Depends only on requests, streak and reset,
    // so nothing from the data phase feeds back into the address phase.
    always_comb begin
        starve = inst_req && GUARD_ON && (streak_reg == STREAK_LIM);
        gnt_d  = data_req && !starve && !reset;
        gnt_i  = inst_req && !gnt_d && !reset;
    end

    assign inst_addr_ok = gnt_i;
    assign data_addr_ok = gnt_d;

    // Issue to the SRAM in the grant cycle; address/strobe/data pass straight through.
    always_comb begin
        mem_en    = gnt_i || gnt_d;
        mem_addr  = gnt_d ? data_addr : inst_addr;
        mem_we    = (gnt_d && data_wr) ? data_wstrb : 4'b0000;
        mem_wdata = data_wdata;
    end

    // Response owner FSM and anti-starvation streak counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            streak_reg <= 3'd0;
        end else begin
            if (gnt_d) begin
                state_reg <= RESP_D;
            end else if (gnt_i) begin
                state_reg <= RESP_I;
            end else begin
                state_reg <= IDLE;
            end

            // A fetch grant or an absent fetch request ends the streak; a data
            // grant over a waiting fetch extends it up to the limit.
            if (gnt_i || !inst_req) begin
                streak_reg <= 3'd0;
            end else if (gnt_d && (streak_reg != STREAK_LIM)) begin
                streak_reg <= streak_reg + 3'd1;
            end
        end
    end

    // Data phase: the owner registered last cycle sees mem_rdata. Reset
    // arriving while a response is due discards it.
    always_comb begin
        inst_data_ok = (state_reg == RESP_I) && !reset;
        data_data_ok = (state_reg == RESP_D) && !reset;
        inst_rdata   = inst_data_ok ? mem_rdata : 32'b0;
        data_rdata   = data_data_ok ? mem_rdata : 32'b0;
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// tb_sram_req_arbiter: drives two arbiters (STREAK_MAX=4 and STREAK_MAX=0)
// from shared stimulus and compares both against a behavioural model that
// tracks the previous grant and the count of data grants past a waiting fetch.
module tb_sram_req_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] mem_rdata;

    logic [1:0]  inst_addr_ok;
    logic [1:0]  inst_data_ok;
    logic [31:0] inst_rdata [2];
    logic [1:0]  data_addr_ok;
    logic [1:0]  data_data_ok;
    logic [31:0] data_rdata [2];
    logic [1:0]  mem_en;
    logic [3:0]  mem_we [2];
    logic [31:0] mem_addr [2];
    logic [31:0] mem_wdata [2];

    sram_req_arbiter #(.STREAK_MAX(4)) dut4 (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok[0]), .inst_data_ok(inst_data_ok[0]), .inst_rdata(inst_rdata[0]),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok[0]), .data_data_ok(data_data_ok[0]), .data_rdata(data_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata)
    );

    sram_req_arbiter #(.STREAK_MAX(0)) dut0 (
        .clk(clk), .reset(reset),
        .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok[1]), .inst_data_ok(inst_data_ok[1]), .inst_rdata(inst_rdata[1]),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok[1]), .data_data_ok(data_data_ok[1]), .data_rdata(data_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: 0 none, 1 fetch, 2 data.
    int m_limit  [2] = '{4, 0};
    int m_streak [2];
    int m_owner  [2];
    int m_gnt    [2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, k, obs, expv);
    endtask

    // Let combinational outputs settle well before the next rising edge.
    task automatic settle();
        #3;
    endtask

    // Compare both instances against the model for the current inputs.
    task automatic check_model();
        for (int k = 0; k < 2; k++) begin
            int g;
            g = 0;
            if (!reset) begin
                if (data_req && !(inst_req && m_limit[k] != 0 && m_streak[k] >= m_limit[k]))
                    g = 2;
                else if (inst_req)
                    g = 1;
            end
            m_gnt[k] = g;
            chk("inst_addr_ok", k, 32'(inst_addr_ok[k]), 32'(g == 1));
            chk("data_addr_ok", k, 32'(data_addr_ok[k]), 32'(g == 2));
            chk("mem_en",       k, 32'(mem_en[k]),       32'(g != 0));
            chk("mem_we",       k, 32'(mem_we[k]),       (g == 2 && data_wr) ? 32'(data_wstrb) : 32'd0);
            chk("mem_addr",     k, mem_addr[k],          (g == 2) ? data_addr : inst_addr);
            chk("mem_wdata",    k, mem_wdata[k],         data_wdata);
            chk("inst_data_ok", k, 32'(inst_data_ok[k]), 32'(!reset && m_owner[k] == 1));
            chk("data_data_ok", k, 32'(data_data_ok[k]), 32'(!reset && m_owner[k] == 2));
            chk("inst_rdata",   k, inst_rdata[k],        (!reset && m_owner[k] == 1) ? mem_rdata : 32'd0);
            chk("data_rdata",   k, data_rdata[k],        (!reset && m_owner[k] == 2) ? mem_rdata : 32'd0);
        end
    endtask

    // Clock edge, then advance the model with the inputs that were applied.
    task automatic advance();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_owner[k]  = 0;
                m_streak[k] = 0;
            end else begin
                m_owner[k] = m_gnt[k];
                if (m_gnt[k] == 2 && inst_req)
                    m_streak[k] = (m_streak[k] < m_limit[k]) ? m_streak[k] + 1 : m_streak[k];
                else
                    m_streak[k] = 0;
            end
        end
    endtask

    task automatic tick();
        settle();
        check_model();
        advance();
    endtask

    task automatic idle_inputs();
        inst_req   = 1'b0;
        inst_addr  = $urandom;
        data_req   = 1'b0;
        data_wr    = 1'b0;
        data_wstrb = 4'($urandom);
        data_addr  = $urandom;
        data_wdata = $urandom;
        mem_rdata  = $urandom;
    endtask

    logic [9:0] order_obs;
    logic [9:0] order_exp;

    initial begin
        reset = 1'b1;
        idle_inputs();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_streak[k] = 0;
            m_owner[k]  = 0;
            m_gnt[k]    = 0;
        end

        // Reset held with both requests pending: nothing granted or returned.
        inst_req = 1'b1;
        data_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mem_rdata = $urandom;
            settle();
            check_model();
            chk("rst_mem_en", 0, 32'(mem_en[0]), 32'd0);
            advance();
        end
        reset = 1'b0;
        settle();
        check_model();
        chk("post_rst_data_gnt", 0, 32'(data_addr_ok[0]), 32'd1);
        advance();

        // Fetch only, then its response.
        idle_inputs();
        inst_req  = 1'b1;
        inst_addr = 32'h1c000000;
        settle();
        check_model();
        chk("fetch_addr", 0, mem_addr[0], 32'h1c000000);
        advance();
        idle_inputs();
        mem_rdata = 32'h02800c0c;
        settle();
        check_model();
        chk("fetch_rdata", 0, inst_rdata[0], 32'h02800c0c);
        advance();

        // Store with partial strobes.
        idle_inputs();
        data_req   = 1'b1;
        data_wr    = 1'b1;
        data_wstrb = 4'b0011;
        data_addr  = 32'h100;
        data_wdata = 32'hdeadbeef;
        settle();
        check_model();
        chk("store_we", 0, 32'(mem_we[0]), 32'h3);
        advance();
        idle_inputs();
        settle();
        check_model();
        chk("store_done", 0, 32'(data_data_ok[0]), 32'd1);
        advance();

        // Both requests held 10 cycles from a cleared streak.
        idle_inputs();
        inst_req = 1'b1;
        data_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_rdata = $urandom;
            settle();
            check_model();
            order_obs[i] = inst_addr_ok[0];
            advance();
        end
        order_exp = 10'b10_0001_0000;
        chk("grant_order", 0, 32'(order_obs), 32'(order_exp));

        // Pure data priority instance never serves fetch while data waits.
        for (int i = 0; i < 8; i++) begin
            mem_rdata = $urandom;
            settle();
            check_model();
            chk("no_guard_fetch", 1, 32'(inst_addr_ok[1]), 32'd0);
            advance();
        end
        data_req = 1'b0;
        settle();
        check_model();
        chk("no_guard_release", 1, 32'(inst_addr_ok[1]), 32'd1);
        advance();

        // Alternating I, D, I then reset discards the final response.
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            inst_req = (i != 1);
            data_req = (i == 1);
            data_wr  = 1'b0;
            tick();
        end
        idle_inputs();
        reset = 1'b1;
        settle();
        check_model();
        chk("rst_discard", 0, 32'(inst_data_ok[0]), 32'd0);
        advance();
        reset = 1'b0;

        // Random traffic, occasional reset.
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 49) == 0);
            inst_req   = ($urandom_range(0, 3) != 0);
            data_req   = ($urandom_range(0, 3) != 0);
            data_wr    = 1'($urandom);
            data_wstrb = 4'($urandom);
            inst_addr  = $urandom;
            data_addr  = $urandom;
            data_wdata = $urandom;
            mem_rdata  = $urandom;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
